// File: rtl/alu_writeback_buffer.sv
// Two-entry in-order writeback buffer between the ALU and the register-file write port.
// It also holds the architectural carry/zero flags and answers decode's pending-write hazard query.
module alu_writeback_buffer #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_carry,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wr_reg,
    input  logic                  in_wr_flag,
    input  logic                  flush,
    input  logic                  rf_ready,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  flag_carry,
    output logic                  flag_zero,
    input  logic [REG_ADDR_W-1:0] hz_addr,
    output logic                  hz_hit,
    output logic                  busy
);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic                  carry;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wr_reg;
        logic                  wr_flag;
    } entry_t;

    // Slot 0 is always the head; a pop shifts slot 1 down.
    entry_t     ent_q [2];
    entry_t     ent_d [2];
    logic [1:0] count_q, count_d;
    logic       flag_carry_q, flag_zero_q;
    logic       push, pop;
    entry_t     new_ent;
    logic [1:0] valid;
    logic [1:0] hit_vec;

    assign in_ready = (count_q != 2'd2);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (count_q != 2'd0) & rf_ready & ~flush;
    assign busy     = (count_q != 2'd0);

    assign new_ent = '{data: in_data, carry: in_carry, dest: in_dest,
                       wr_reg: in_wr_reg, wr_flag: in_wr_flag};

    assign wr_en   = pop & ent_q[0].wr_reg;
    assign wr_addr = busy ? ent_q[0].dest : '0;
    assign wr_data = busy ? ent_q[0].data : '0;

    assign valid = {count_q == 2'd2, count_q != 2'd0};

    // The head still counts as pending in the cycle it retires.
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
        assign hit_vec[gi] = valid[gi] & ent_q[gi].wr_reg & (ent_q[gi].dest == hz_addr);
    end
    assign hz_hit = |hit_vec;

    assign flag_carry = flag_carry_q;
    assign flag_zero  = flag_zero_q;

    always_comb begin
        ent_d   = ent_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push && pop) begin
            // Only reachable from ONE: the incoming entry replaces the retiring head.
            ent_d[0] = new_ent;
        end else if (pop) begin
            ent_d[0] = ent_q[1];
            count_d  = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                ent_d[0] = new_ent;
            end else begin
                ent_d[1] = new_ent;
            end
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 2'd0;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= ent_d[i];
            end
            if (pop && ent_q[0].wr_flag) begin
                flag_carry_q <= ent_q[0].carry;
                flag_zero_q  <= (ent_q[0].data == '0);
            end
        end
    end

endmodule
